hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the 5-stage hazard detection unit.
- Generates per-stage stall/flush vectors for an N-stage pipeline.
- Tracks multi-cycle MDU operations with its own FSM and timeout, instead of relying on a level stall from EX.
- Adds data-memory wait stalls, trap flush-all, and saturating performance counters. Sits in core/ctrl between forwarding/EX/MEM and the pipeline registers.

Parameters:
- NUM_STAGES, 5, width of stall_o/flush_o. Bit 0 = PC; bit k = pipeline register k; bit NUM_STAGES-1 = MEM/WB. Legal range 4..8.
- EX_STAGE, 2, index of the register feeding EX (ID/EX). Legal range 2..NUM_STAGES-2.
- MDU_TIMEOUT, 64, maximum BUSY cycles before forced release. Must be at least 2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, asynchronous active-low reset.
- load_hazard_i, input, 1, load-use hazard from forwarding unit.
- jump_i, input, 1, taken branch/jump resolved in EX.
- mdu_start_i, input, 1, M-type instruction issuing in EX this cycle.
- mdu_done_i, input, 1, MDU result valid this cycle.
- mem_stall_i, input, 1, data memory not ready.
- trap_flush_i, input, 1, trap/interrupt redirect.
- cnt_clr_i, input, 1, synchronous clear of performance counters.
- stall_o, output, NUM_STAGES, per-stage stall.
- flush_o, output, NUM_STAGES, per-stage flush.
- mdu_busy_o, output, 1, FSM is in BUSY.
- mdu_timeout_o, output, 1, sticky: a timeout occurred.
- stall_cycles_o, output, CNT_W, count of cycles with stall_o[0]=1.
- flush_events_o, output, CNT_W, count of cycles with jump or trap flush applied.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - FSM goes to IDLE; timeout counter, both perf counters and mdu_timeout_o are cleared.
  - stall_o and flush_o are forced to 0 combinationally while reset is held.
- stall_o/flush_o are combinational from inputs and FSM state (zero latency). All other outputs are registered.
- mdu_active = mdu_start_i in IDLE, or state==BUSY with mdu_done_i=0.
- Priority (highest first), exactly one pattern applies per cycle:
  1. trap_flush_i: flush bits 1..NUM_STAGES-1; no stalls.
  2. mem_stall_i: stall bits 0..NUM_STAGES-2; flush bit NUM_STAGES-1.
  3. mdu_active: stall bits 0..EX_STAGE.
  4. jump_i: flush bits 1..EX_STAGE.
  5. load_hazard_i: stall bits 0..EX_STAGE-1; flush bit EX_STAGE.
  6. Otherwise all zero.
- MDU FSM, two states:
  - IDLE: on mdu_start_i (and no trap_flush_i), go to BUSY and load tcnt=1.
  - BUSY: tcnt increments each cycle, including cycles under mem_stall_i.
  - BUSY, mdu_done_i=1: go to IDLE. Stall is released in that same cycle.
  - BUSY, tcnt==MDU_TIMEOUT without done: go to IDLE and set mdu_timeout_o. The stall is released in the cycle where tcnt==MDU_TIMEOUT is observed.
  - trap_flush_i in any state: go to IDLE (aborts the op); timeout flag is not set.
  - mdu_done_i while IDLE is ignored.
  - mdu_done_i during mem_stall_i still returns the FSM to IDLE; the MDU holds its result until EX advances.
- mdu_timeout_o is sticky until reset.
- Perf counters:
  - Saturate at all-ones; no wrap.
  - cnt_clr_i has priority over increment in the same cycle; the cycle's event is dropped.
- mdu_start_i while BUSY is illegal and ignored; the bench asserts it never occurs.

Test Plan:
- Reset release, then idle: stall_o=00000, flush_o=00000, counters=0, mdu_busy_o=0.
- load_hazard_i=1 for 1 cycle -> stall_o=00011, flush_o=00100. Next cycle stall_cycles_o=1.
- mdu_start_i at cycle 0, mdu_done_i at cycle 4:
  - cycles 0–3: stall_o=00111.
  - cycle 4: stall_o=00000.
  - mdu_busy_o high for cycles 1–4 (registered).
  - stall_cycles_o=4.
- MDU started with no done, MDU_TIMEOUT=64:
  - stall holds for cycles 0–63 (64 cycles) and drops at cycle 64.
  - mdu_timeout_o=1 from cycle 65 onward.
- mem_stall_i and jump_i together -> stall_o=01111, flush_o=10000. Then jump alone -> flush_o=00110; flush_events_o increments by 1.
- trap_flush_i during BUSY -> flush_o=11110, stall_o=00000; FSM returns to IDLE and mdu_timeout_o stays 0.
- Saturation: run CNT_W=4 to 15 stall cycles; further stalls leave stall_cycles_o=15. cnt_clr_i together with a stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: per-stage stall/flush generation, MDU busy tracking with a
// timeout, and saturating stall/flush performance counters.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   load_hazard_i        load-use hazard
//   jump_i               taken branch/jump resolved in EX
//   mdu_start_i          M-type op issuing in EX
//   mdu_done_i           MDU result valid
//   mem_stall_i          data memory not ready
//   trap_flush_i         trap/interrupt redirect
//   cnt_clr_i            clear performance counters
//   stall_o, flush_o     per-stage stall/flush (bit 0 = PC)
//   mdu_busy_o           MDU FSM in BUSY
//   mdu_timeout_o        sticky MDU timeout flag
//   stall_cycles_o       cycles with PC stalled
//   flush_events_o       cycles with jump/trap flush applied
module hazard_ctrl_unit #(
  parameter int NUM_STAGES  = 5,
  parameter int EX_STAGE    = 2,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_hazard_i,
  input  logic                  jump_i,
  input  logic                  mdu_start_i,
  input  logic                  mdu_done_i,
  input  logic                  mem_stall_i,
  input  logic                  trap_flush_i,
  input  logic                  cnt_clr_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  mdu_busy_o,
  output logic                  mdu_timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_events_o
);

  localparam int TW = $clog2(MDU_TIMEOUT + 1);

  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] TRAP_FL = ~ONE;
  localparam logic [NUM_STAGES-1:0] MEM_ST =
    (ONE << (NUM_STAGES - 1)) - ONE;
  localparam logic [NUM_STAGES-1:0] MEM_FL = ONE << (NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] MDU_ST =
    (ONE << (EX_STAGE + 1)) - ONE;
  localparam logic [NUM_STAGES-1:0] JMP_FL = MDU_ST & ~ONE;
  localparam logic [NUM_STAGES-1:0] LD_ST = (ONE << EX_STAGE) - ONE;
  localparam logic [NUM_STAGES-1:0] LD_FL = ONE << EX_STAGE;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  sc_q, sc_d;
  logic [CNT_W-1:0]  fe_q, fe_d;

  logic                  tmo_hit;
  logic                  mdu_active;
  logic                  flush_ev;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_raw;

  // The stall drops in the very cycle done or the timeout is seen.
  assign tmo_hit = (state_q == BUSY) && (tcnt_q == TW'(MDU_TIMEOUT));
  assign mdu_active = ((state_q == IDLE) && mdu_start_i) ||
                      ((state_q == BUSY) && !mdu_done_i && !tmo_hit);

  always_comb begin
    stall_raw = '0;
    flush_raw = '0;
    flush_ev  = 1'b0;
    if (trap_flush_i) begin
      flush_raw = TRAP_FL;
      flush_ev  = 1'b1;
    end else if (mem_stall_i) begin
      stall_raw = MEM_ST;
      flush_raw = MEM_FL;
    end else if (mdu_active) begin
      stall_raw = MDU_ST;
    end else if (jump_i) begin
      flush_raw = JMP_FL;
      flush_ev  = 1'b1;
    end else if (load_hazard_i) begin
      stall_raw = LD_ST;
      flush_raw = LD_FL;
    end
  end

  assign stall_o = rst_ni ? stall_raw : '0;
  assign flush_o = rst_ni ? flush_raw : '0;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
    if (trap_flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mdu_start_i) begin
            state_d = BUSY;
            tcnt_d  = TW'(1);
          end
        end
        BUSY: begin
          if (mdu_done_i) begin
            state_d = IDLE;
          end else if (tmo_hit) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sc_d = sc_q;
    fe_d = fe_q;
    if (cnt_clr_i) begin
      sc_d = '0;
      fe_d = '0;
    end else begin
      if (stall_raw[0] && (sc_q != '1)) sc_d = sc_q + CNT_W'(1);
      if (flush_ev && (fe_q != '1)) fe_d = fe_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
      sc_q    <= '0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      tmo_q   <= tmo_d;
      sc_q    <= sc_d;
      fe_q    <= fe_d;
    end
  end

  assign mdu_busy_o     = (state_q == BUSY);
  assign mdu_timeout_o  = tmo_q;
  assign stall_cycles_o = sc_q;
  assign flush_events_o = fe_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: per-cycle model pushes expectations to a
// scoreboard queue; each scenario task pops and compares.
module tb_hazard_ctrl_unit;

  localparam int TMO  = 64;
  localparam int MAXC = 15;

  localparam logic [6:0] IDL = 7'b0000000;
  localparam logic [6:0] LH  = 7'b1000000;
  localparam logic [6:0] JP  = 7'b0100000;
  localparam logic [6:0] ST  = 7'b0010000;
  localparam logic [6:0] DN  = 7'b0001000;
  localparam logic [6:0] MS  = 7'b0000100;
  localparam logic [6:0] TR  = 7'b0000010;
  localparam logic [6:0] CL  = 7'b0000001;

  typedef struct packed {
    logic [4:0] st;
    logic [4:0] fl;
    logic       b;
    logic       t;
    logic [3:0] sc;
    logic [3:0] fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_hazard = 1'b0;
  logic       jump = 1'b0;
  logic       mdu_start = 1'b0;
  logic       mdu_done = 1'b0;
  logic       mem_stall = 1'b0;
  logic       trap_flush = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [4:0] stall_o;
  logic [4:0] flush_o;
  logic       mdu_busy_o;
  logic       mdu_timeout_o;
  logic [3:0] stall_cycles_o;
  logic [3:0] flush_events_o;

  int total = 0;
  int bad = 0;

  exp_t sb [$];

  logic m_busy = 1'b0;
  logic m_tmo = 1'b0;
  int   m_tcnt = 0;
  int   m_sc = 0;
  int   m_fe = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .NUM_STAGES (5),
    .EX_STAGE   (2),
    .MDU_TIMEOUT(TMO),
    .CNT_W      (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_hazard_i (load_hazard),
    .jump_i        (jump),
    .mdu_start_i   (mdu_start),
    .mdu_done_i    (mdu_done),
    .mem_stall_i   (mem_stall),
    .trap_flush_i  (trap_flush),
    .cnt_clr_i     (cnt_clr),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mdu_busy_o    (mdu_busy_o),
    .mdu_timeout_o (mdu_timeout_o),
    .stall_cycles_o(stall_cycles_o),
    .flush_events_o(flush_events_o)
  );

  task automatic drive(input logic [6:0] v);
    exp_t e;
    logic act;
    logic fev;
    logic [4:0] s;
    logic [4:0] f;
    @(negedge clk);
    {load_hazard, jump, mdu_start, mdu_done,
     mem_stall, trap_flush, cnt_clr} = v;
    assert (!(mdu_start && m_busy))
      else $error("mdu_start driven while MDU busy");
    #1;
    act = (!m_busy && mdu_start) ||
          (m_busy && !mdu_done && (m_tcnt != TMO));
    s = 5'b0;
    f = 5'b0;
    fev = 1'b0;
    if (trap_flush) begin
      f = 5'b11110;
      fev = 1'b1;
    end else if (mem_stall) begin
      s = 5'b01111;
      f = 5'b10000;
    end else if (act) begin
      s = 5'b00111;
    end else if (jump) begin
      f = 5'b00110;
      fev = 1'b1;
    end else if (load_hazard) begin
      s = 5'b00011;
      f = 5'b00100;
    end
    e.st = s;
    e.fl = f;
    e.b  = m_busy;
    e.t  = m_tmo;
    e.sc = 4'(m_sc);
    e.fe = 4'(m_fe);
    sb.push_back(e);
    if (cnt_clr) begin
      m_sc = 0;
      m_fe = 0;
    end else begin
      if (s[0] && m_sc < MAXC) m_sc++;
      if (fev && m_fe < MAXC) m_fe++;
    end
    if (trap_flush) m_busy = 1'b0;
    else if (!m_busy) begin
      if (mdu_start) begin
        m_busy = 1'b1;
        m_tcnt = 1;
      end
    end else if (mdu_done) m_busy = 1'b0;
    else if (m_tcnt == TMO) begin
      m_busy = 1'b0;
      m_tmo = 1'b1;
    end else m_tcnt++;
  endtask

  task automatic test_reset();
    load_hazard = 1'b1;
    trap_flush = 1'b1;
    #3;
    total++;
    if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
         stall_cycles_o, flush_events_o} !== 20'h0) begin
      bad++;
      $display("FAIL reset got st=%b fl=%b b=%b t=%b sc=%0d fe=%0d want 0",
               stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
               stall_cycles_o, flush_events_o);
    end
    @(negedge clk);
    load_hazard = 1'b0;
    trap_flush = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_load_hazard();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{IDL, CL, LH, IDL};
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL load_hazard[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
    total++;
    if (stall_cycles_o !== 4'd1) begin
      bad++;
      $display("FAIL load_hazard_cnt got=%0d want=1", stall_cycles_o);
    end
  endtask

  task automatic test_mdu_done();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL, ST, IDL, IDL, IDL, DN, IDL};
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL mdu_done[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
    total++;
    if (stall_cycles_o !== 4'd4 || mdu_busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mdu_done_end got sc=%0d busy=%b want sc=4 busy=0",
               stall_cycles_o, mdu_busy_o);
    end
  endtask

  task automatic test_mem_jump();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL, MS | JP, JP, IDL};
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL mem_jump[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
    total++;
    if (flush_events_o !== 4'd1) begin
      bad++;
      $display("FAIL mem_jump_fe got=%0d want=1", flush_events_o);
    end
  endtask

  task automatic test_trap_busy();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL, ST, IDL, IDL, TR, IDL, IDL, TR | ST, IDL};
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL trap_busy[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL, ST, IDL, DN, ST, MS | DN, DN, IDL,
             ST, JP, DN | JP, IDL, LH, IDL};
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL, ST};
    for (int k = 0; k < TMO + 2; k++) stim.push_back(IDL);
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL timeout[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
    total++;
    if (mdu_timeout_o !== 1'b1 || stall_o !== 5'b0) begin
      bad++;
      $display("FAIL timeout_end got t=%b st=%b want t=1 st=00000",
               mdu_timeout_o, stall_o);
    end
  endtask

  task automatic test_saturation();
    logic [6:0] stim [$];
    exp_t e;
    stim = '{CL};
    for (int k = 0; k < 17; k++) stim.push_back(LH);
    for (int k = 0; k < 17; k++) stim.push_back(JP);
    stim.push_back(IDL);
    stim.push_back(CL | LH);
    stim.push_back(IDL);
    foreach (stim[i]) begin
      drive(stim[i]);
      e = sb.pop_front();
      total++;
      if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
           stall_cycles_o, flush_events_o} !== e) begin
        bad++;
        $display("FAIL saturation[%0d] got=%h want=%h", i,
                 {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                  stall_cycles_o, flush_events_o}, e);
      end
    end
    total++;
    if (stall_cycles_o !== 4'd0 || flush_events_o !== 4'd0) begin
      bad++;
      $display("FAIL saturation_clr got sc=%0d fe=%0d want 0 0",
               stall_cycles_o, flush_events_o);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive(ST);
    e = sb.pop_front();
    total++;
    if (stall_o !== e.st) begin
      bad++;
      $display("FAIL async_pre got st=%b want=%b", stall_o, e.st);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o} !== 12'h0) begin
      bad++;
      $display("FAIL async_reset got st=%b fl=%b b=%b t=%b want 0",
               stall_o, flush_o, mdu_busy_o, mdu_timeout_o);
    end
    m_busy = 1'b0;
    m_tmo = 1'b0;
    m_tcnt = 0;
    m_sc = 0;
    m_fe = 0;
    @(negedge clk);
    mdu_start = 1'b0;
    rst_n = 1'b1;
    drive(IDL);
    e = sb.pop_front();
    total++;
    if ({stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
         stall_cycles_o, flush_events_o} !== e) begin
      bad++;
      $display("FAIL async_post got=%h want=%h",
               {stall_o, flush_o, mdu_busy_o, mdu_timeout_o,
                stall_cycles_o, flush_events_o}, e);
    end
  endtask

  initial begin
    test_reset();
    test_load_hazard();
    test_mdu_done();
    test_mem_jump();
    test_trap_busy();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
